// File: rtl/mux_scan_pkg.sv
// Shared types and defaults for the mux scan sequencer.
// The optional skip mode is enabled by defining MUX_SCAN_SKIP_IDLE_EN.
package mux_scan_pkg;

    localparam int N_CH_DEF  = 4;
    localparam int DWELL_DEF = 2;
    localparam int SEL_W_DEF = $clog2(N_CH_DEF);

    typedef logic [SEL_W_DEF-1:0] sel_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

endpackage

// File: rtl/mux_scan_sequencer_rr_next_ch.sv
// Cyclic priority search: first requesting channel at or after ptr.
// Only used when MUX_SCAN_SKIP_IDLE_EN is defined.
module rr_next_ch
    import mux_scan_pkg::*;
#(
    parameter  int N_CH  = N_CH_DEF,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] next_ch,
    output logic             found
);

    // Scan offsets 0..N_CH-1 from ptr; index arithmetic wraps since N_CH is a power of 2.
    always_comb begin
        logic [SEL_W-1:0] idx_s;
        logic             hit_s;
        next_ch = ptr;
        found   = 1'b0;
        idx_s   = ptr;
        hit_s   = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            idx_s   = ptr + SEL_W'(i);
            hit_s   = req[idx_s] & ~found;
            next_ch = hit_s ? idx_s : next_ch;
            found   = found | req[idx_s];
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Round-robin scanner for a 4:1 mux: drives sel, waits DWELL cycles, samples mux_y
// and offers (channel, bit) on a valid/ready port. Skip mode: MUX_SCAN_SKIP_IDLE_EN.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter  int N_CH  = N_CH_DEF,
    parameter  int DWELL = DWELL_DEF,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_CH-1:0]  req,
    input  logic             mux_y,
    output logic [SEL_W-1:0] sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [SEL_W-1:0] out_ch,
    output logic             scan_done
);

    localparam int CNT_W = $clog2(DWELL + 1);

    state_t           state_r;
    logic [SEL_W-1:0] sel_r;
    logic [SEL_W-1:0] ptr_r;
    logic [CNT_W-1:0] dwell_r;
    logic             out_valid_r;
    logic             out_bit_r;
    logic [SEL_W-1:0] out_ch_r;
    logic             scan_done_r;

    logic [SEL_W-1:0] ptr_next_s;
    logic [SEL_W-1:0] search_ptr_s;
    logic [SEL_W-1:0] next_s;
    logic             found_s;
    logic             handshake_s;

    assign handshake_s  = out_valid_r & out_ready;
    assign ptr_next_s   = out_ch_r + SEL_W'(1);
    // On the handshake edge the search must start past the channel just delivered.
    assign search_ptr_s = (state_r == ST_OUTPUT) ? ptr_next_s : ptr_r;

`ifdef MUX_SCAN_SKIP_IDLE_EN
    rr_next_ch #(
        .N_CH (N_CH)
    ) u_rr_next_ch (
        .req     (req),
        .ptr     (search_ptr_s),
        .next_ch (next_s),
        .found   (found_s)
    );
`else
    logic req_unused_s;
    assign req_unused_s = ^req;
    assign next_s       = search_ptr_s;
    assign found_s      = 1'b1;
`endif

    // Scan FSM with dwell counter; every output comes straight from these flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            sel_r       <= {SEL_W{1'b0}};
            ptr_r       <= {SEL_W{1'b0}};
            dwell_r     <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
            out_bit_r   <= 1'b0;
            out_ch_r    <= {SEL_W{1'b0}};
            scan_done_r <= 1'b0;
        end else begin
            scan_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (en && found_s) begin
                        state_r <= ST_SETTLE;
                        sel_r   <= next_s;
                        dwell_r <= CNT_W'(DWELL - 1);
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (dwell_r == {CNT_W{1'b0}}) begin
                        out_bit_r   <= mux_y;
                        out_ch_r    <= sel_r;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_OUTPUT;
                    end else begin
                        dwell_r <= dwell_r - CNT_W'(1);
                    end
                end
                ST_OUTPUT: begin
                    if (handshake_s) begin
                        out_valid_r <= 1'b0;
                        ptr_r       <= ptr_next_s;
                        scan_done_r <= (out_ch_r == SEL_W'(N_CH - 1));
                        if (en && found_s) begin
                            state_r <= ST_SETTLE;
                            sel_r   <= next_s;
                            dwell_r <= CNT_W'(DWELL - 1);
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_OUTPUT;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign sel       = sel_r;
    assign out_valid = out_valid_r;
    assign out_bit   = out_bit_r;
    assign out_ch    = out_ch_r;
    assign scan_done = scan_done_r;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer with a behavioural 4:1 mux (mux_y = d[sel]).
// Skip-mode sequences run only when MUX_SCAN_SKIP_IDLE_EN is defined.
module tb_mux_scan_sequencer;
    import mux_scan_pkg::*;

    localparam int N_CH  = 4;
    localparam int DWELL = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic       mux_y;
    sel_t       sel;
    logic       out_valid;
    logic       out_ready;
    logic       out_bit;
    sel_t       out_ch;
    logic       scan_done;
    logic [3:0] d;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;
    assign mux_y = d[sel];

    mux_scan_sequencer #(.N_CH(N_CH), .DWELL(DWELL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .mux_y     (mux_y),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_ch    (out_ch),
        .scan_done (scan_done)
    );

    typedef struct {
        int   ch;
        logic b;
        logic done;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output int waited);
        waited = 0;
        while (!out_valid && waited < budget) begin
            tick();
            waited++;
        end
        chk("valid_seen", {31'd0, out_valid}, 32'd1);
    endtask

    // Reference: which channel is visited next when the search starts at p.
    function automatic int model_next(input int p);
`ifdef MUX_SCAN_SKIP_IDLE_EN
        for (int k = 0; k < N_CH; k++) begin
            if (req[(p + k) % N_CH]) return (p + k) % N_CH;
        end
        return -1;
`else
        return p % N_CH;
`endif
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Drive a list of expected samples with out_ready high and check order, data, timing, scan_done.
    task automatic run_table(input vec_t tbl[$], input string tag);
        int w;
        for (int i = 0; i < tbl.size(); i++) begin
            wait_valid(20, w);
            chk({tag, "_lat"}, w, (i == 0) ? DWELL + 1 : DWELL);
            chk({tag, "_ch"}, out_ch, tbl[i].ch);
            chk({tag, "_bit"}, {31'd0, out_bit}, {31'd0, tbl[i].b});
            tick();
            chk({tag, "_vld_drop"}, {31'd0, out_valid}, 32'd0);
            chk({tag, "_done"}, {31'd0, scan_done}, {31'd0, tbl[i].done});
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t t2[$];
        int   w;
        int   exp_ptr;
        int   since;
        int   e;
        logic pv, pr, pb;
        sel_t pch, psel;

        rst_n = 1'b0; en = 1'b1; req = 4'b0000; out_ready = 1'b1; d = 4'b1010;

        // 1: reset held with en high
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_sel", sel, 0);
            chk("rst_valid", {31'd0, out_valid}, 0);
            chk("rst_done", {31'd0, scan_done}, 0);
        end
        chk("rst_ch", out_ch, 0);
        chk("rst_bit", {31'd0, out_bit}, 0);

`ifndef MUX_SCAN_SKIP_IDLE_EN
        // 2: ordered scan, d=1010
        t2.push_back('{0, 1'b0, 1'b0});
        t2.push_back('{1, 1'b1, 1'b0});
        t2.push_back('{2, 1'b0, 1'b0});
        t2.push_back('{3, 1'b1, 1'b1});
        t2.push_back('{0, 1'b0, 1'b0});
        rst_n = 1'b1;
        run_table(t2, "scan");

        // 3: backpressure on ch1
        out_ready = 1'b0;
        wait_valid(20, w);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", {31'd0, out_valid}, 1);
            chk("bp_ch", out_ch, 1);
            chk("bp_bit", {31'd0, out_bit}, 1);
            chk("bp_sel", sel, 1);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release", {31'd0, out_valid}, 0);

        // 4a: en dropped during SETTLE of ch2
        chk("dis_sel_settle", sel, 2);
        en = 1'b0;
        wait_valid(20, w);
        chk("dis_ch", out_ch, 2);
        chk("dis_bit", {31'd0, out_bit}, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("dis_idle_valid", {31'd0, out_valid}, 0);
            chk("dis_idle_sel", sel, 2);
        end

        // 4b: reset during OUTPUT drops the sample and restarts at ch0
        out_ready = 1'b0;
        en = 1'b1;
        wait_valid(20, w);
        chk("rs_ch3", out_ch, 3);
        rst_n = 1'b0;
        tick();
        chk("rs_valid", {31'd0, out_valid}, 0);
        chk("rs_sel", sel, 0);
        chk("rs_done", {31'd0, scan_done}, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        wait_valid(20, w);
        chk("rs_lat", w, DWELL + 1);
        chk("rs_ch0", out_ch, 0);
        tick();
        chk("rs_nodone", {31'd0, scan_done}, 0);
`else
        // 5: skip mode, req=1001, d=1000
        d = 4'b1000; req = 4'b1001;
        rst_n = 1'b1;
        wait_valid(20, w);
        chk("skip_ch0", out_ch, 0);
        chk("skip_b0", {31'd0, out_bit}, 0);
        tick();
        wait_valid(20, w);
        chk("skip_ch3", out_ch, 3);
        chk("skip_b3", {31'd0, out_bit}, 1);
        tick();
        chk("skip_done", {31'd0, scan_done}, 1);
        wait_valid(20, w);
        chk("skip_ch0b", out_ch, 0);
        req = 4'b0000;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("skip_idle", {31'd0, out_valid}, 0);
        end

        // 6: wrap from ptr=3 with only ch1 requesting
        do_reset();
        req = 4'b0100; out_ready = 1'b0;
        wait_valid(20, w);
        chk("wrap_ch2", out_ch, 2);
        req = 4'b0010; out_ready = 1'b1;
        tick();
        wait_valid(20, w);
        chk("wrap_ch1", out_ch, 1);
        chk("wrap_bit", {31'd0, out_bit}, {31'd0, d[1]});
        tick();
`endif

        // Randomized runs against the reference model
        for (int run = 0; run < 4; run++) begin
            d   = 4'($urandom);
            req = 4'($urandom_range(1, 15));
            en  = 1'b1;
            do_reset();
            exp_ptr = 0;
            since   = -1;
            for (int c = 0; c < 150; c++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                pv = out_valid; pr = out_ready; pch = out_ch; pb = out_bit; psel = sel;
                tick();
                if (pv && pr) begin
                    e = model_next(exp_ptr);
                    chk("rnd_ch", pch, e);
                    chk("rnd_bit", {31'd0, pb}, {31'd0, d[e % N_CH]});
                    chk("rnd_done", {31'd0, scan_done}, (e == N_CH - 1) ? 1 : 0);
                    exp_ptr = (e + 1) % N_CH;
                    since = 0;
                end else if (pv) begin
                    chk("rnd_hold_v", {31'd0, out_valid}, 1);
                    chk("rnd_hold_ch", out_ch, pch);
                    chk("rnd_hold_bit", {31'd0, out_bit}, {31'd0, pb});
                    chk("rnd_hold_sel", sel, psel);
                    chk("rnd_nodone", {31'd0, scan_done}, 0);
                end else begin
                    since++;
                    chk("rnd_nodone", {31'd0, scan_done}, 0);
                    if (out_valid) chk("rnd_gap", since, DWELL);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
